// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Sequences the ID-stage branch comparator of the pipelined MIPS core.
// The block checks the branch source registers against the EX/MEM/WB
// destinations and stalls IF/ID long enough for the producer to reach a
// forwardable stage. It selects the comparator operand sources and drives
// the comparator op code. The comparator result becomes a one-cycle
// redirect/flush pulse. A saturating counter records branch stall cycles.
//
// Ports
//   clk, rst_n           : clock (rising edge), async active-low reset
//   BranchValid          : ID stage holds a conditional branch
//   BranchOp[2:0]        : 000 BEQ, 001 BGEZ, 010 BGTZ, 011 BLEZ,
//                          100 BLTZ, 101 BNE (110/111 are treated as no-ops)
//   Rs, Rt [4:0]         : branch sources (Rt is only used by BEQ/BNE)
//   EX_*/MEM_*/WB_*      : downstream writeback enables, load flags and
//                          destination registers
//   Flush                : external flush; aborts a pending branch
//   CmpResult            : comparator result
//   CmpControl[2:0]      : op code to the comparator
//   ForwardA/B[1:0]      : 00 regfile, 01 MEM ALU result, 10 WB result
//   Stall                : freeze PC and IF/ID
//   Taken                : redirect PC to the branch target and flush IF/ID
//   StallCount[CNT_W-1:0]: saturating count of branch stall cycles
// ---------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             BranchValid,
  input  logic [2:0]       BranchOp,
  input  logic [4:0]       Rs,
  input  logic [4:0]       Rt,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rd,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_Rd,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_Rd,
  input  logic             Flush,
  input  logic             CmpResult,
  output logic [2:0]       CmpControl,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             Stall,
  output logic             Taken,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Classify one operand against the pipeline. The result is packed as
  // {match, pos[1:0], need[1:0]}. Here pos is the producer's distance from
  // WB (EX=2, MEM=1, WB=0), and need is the number of stall cycles required.
  function automatic logic [4:0] classify(
    input logic       chk,
    input logic [4:0] r,
    input logic       ex_w,
    input logic       ex_m,
    input logic [4:0] ex_rd,
    input logic       mem_w,
    input logic       mem_m,
    input logic [4:0] mem_rd,
    input logic       wb_w,
    input logic [4:0] wb_rd
  );
    logic [4:0] c;
    c = 5'b0;
    if (chk && (r != 5'd0)) begin
      if (ex_w && (ex_rd == r)) begin
        c = ex_m ? {1'b1, 2'd2, 2'd2} : {1'b1, 2'd2, 2'd1};
      end else if (mem_w && (mem_rd == r)) begin
        c = mem_m ? {1'b1, 2'd1, 2'd1} : {1'b1, 2'd1, 2'd0};
      end else if (wb_w && (wb_rd == r)) begin
        c = {1'b1, 2'd0, 2'd0};
      end
    end
    return c;
  endfunction

  // The forward select depends on where the producer sits once the branch
  // has waited `need` cycles. If the producer is in MEM, the ALU result is
  // forwarded (01). If it is in WB, the WB result is forwarded (10). If it
  // has already retired, the register file holds the value (00). With
  // need=0 this gives the live same-cycle selection.
  function automatic logic [1:0] fwd_sel(input logic [4:0] c, input logic [1:0] need);
    logic [2:0] d;
    logic [1:0] f;
    d = {1'b0, c[3:2]} - {1'b0, need};
    f = 2'b00;
    if (c[4]) begin
      if (d == 3'd1) begin
        f = 2'b01;
      end else if (d == 3'd0) begin
        f = 2'b10;
      end
    end
    return f;
  endfunction

  logic [0:0] state, next_state;
  logic [1:0] cnt, next_cnt;
  logic [2:0] cap_op;
  logic [1:0] cap_fwd_a, cap_fwd_b;
  logic       capture;
  logic       op_valid, use_rt;
  logic [4:0] cls_a, cls_b;
  logic [1:0] need_max;
  logic [1:0] fwd_a, fwd_b;

  assign op_valid = (BranchOp <= 3'b101);
  assign use_rt   = (BranchOp == 3'b000) || (BranchOp == 3'b101);

  assign cls_a = classify(1'b1, Rs, EX_RegWrite, EX_MemRead, EX_Rd,
                          MEM_RegWrite, MEM_MemRead, MEM_Rd, WB_RegWrite, WB_Rd);
  assign cls_b = classify(use_rt, Rt, EX_RegWrite, EX_MemRead, EX_Rd,
                          MEM_RegWrite, MEM_MemRead, MEM_Rd, WB_RegWrite, WB_Rd);

  assign need_max = (cls_a[1:0] > cls_b[1:0]) ? cls_a[1:0] : cls_b[1:0];
  assign fwd_a    = fwd_sel(cls_a, need_max);
  assign fwd_b    = fwd_sel(cls_b, need_max);

  // Mealy output and next-state logic. All outputs are forced to their
  // reset values while rst_n is low. This makes a reset during WAIT clear
  // them immediately, without waiting for an edge.
  always_comb begin
    Stall      = 1'b0;
    Taken      = 1'b0;
    ForwardA   = 2'b00;
    ForwardB   = 2'b00;
    CmpControl = 3'b000;
    next_state = state;
    next_cnt   = cnt;
    capture    = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          CmpControl = BranchOp;
          if (BranchValid && op_valid && !Flush) begin
            if (need_max == 2'd0) begin
              ForwardA = fwd_a;
              ForwardB = fwd_b;
              Taken    = CmpResult;
            end else begin
              Stall      = 1'b1;
              capture    = 1'b1;
              next_cnt   = need_max - 2'd1;
              next_state = WAIT;
            end
          end
        end
        WAIT: begin
          CmpControl = cap_op;
          ForwardA   = cap_fwd_a;
          ForwardB   = cap_fwd_b;
          if (Flush) begin
            next_state = IDLE;
          end else if (cnt != 2'd0) begin
            Stall    = 1'b1;
            next_cnt = cnt - 2'd1;
          end else begin
            Taken      = CmpResult;
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State, captured branch context and the saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      cap_op     <= 3'b000;
      cap_fwd_a  <= 2'b00;
      cap_fwd_b  <= 2'b00;
      StallCount <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (capture) begin
        cap_op    <= BranchOp;
        cap_fwd_a <= fwd_a;
        cap_fwd_b <= fwd_b;
      end
      if (Stall && (StallCount != {CNT_W{1'b1}})) begin
        StallCount <= StallCount + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//
// Self-checking bench for branch_resolve_ctrl. Each stimulus record pushes
// its expected outputs onto a scoreboard queue. The record is popped and
// compared mid-cycle, before the next rising edge. Expected stall counts come
// from a bench-side model that follows the expected Stall values. A second
// instance with a 4-bit counter shares the same stimulus, so counter
// saturation is reached in a few cycles.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  typedef struct {
    string      name;
    logic       valid;
    logic [2:0] op;
    logic [4:0] rs, rt;
    logic       exW, exM;
    logic [4:0] exRd;
    logic       memW, memM;
    logic [4:0] memRd;
    logic       wbW;
    logic [4:0] wbRd;
    logic       flush, cmp;
    logic [2:0] expCtl;
    logic [1:0] expFa, expFb;
    logic       expStall, expTaken;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] ctl;
    logic [1:0] fa, fb;
    logic       stall, taken;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  logic        clk, rst_n;
  logic        BranchValid;
  logic [2:0]  BranchOp;
  logic [4:0]  Rs, Rt;
  logic        EX_RegWrite, EX_MemRead;
  logic [4:0]  EX_Rd;
  logic        MEM_RegWrite, MEM_MemRead;
  logic [4:0]  MEM_Rd;
  logic        WB_RegWrite;
  logic [4:0]  WB_Rd;
  logic        Flush, CmpResult;
  logic [2:0]  CmpControl;
  logic [1:0]  ForwardA, ForwardB;
  logic        Stall, Taken;
  logic [15:0] StallCount;

  logic [2:0]  satCmpControl;
  logic [1:0]  satForwardA, satForwardB;
  logic        satStall, satTaken;
  logic [3:0]  satStallCount;

  exp_t        expQ[$];
  int          passedCount = 0;
  int          totalCount  = 0;
  logic [15:0] modelCnt  = 16'd0;
  logic [3:0]  modelCnt4 = 4'd0;

  branch_resolve_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .BranchValid(BranchValid), .BranchOp(BranchOp),
    .Rs(Rs), .Rt(Rt), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_Rd(EX_Rd), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_Rd(MEM_Rd), .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .Flush(Flush),
    .CmpResult(CmpResult), .CmpControl(CmpControl), .ForwardA(ForwardA),
    .ForwardB(ForwardB), .Stall(Stall), .Taken(Taken), .StallCount(StallCount)
  );

  branch_resolve_ctrl #(.CNT_W(4)) dutSat (
    .clk(clk), .rst_n(rst_n), .BranchValid(BranchValid), .BranchOp(BranchOp),
    .Rs(Rs), .Rt(Rt), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_Rd(EX_Rd), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_Rd(MEM_Rd), .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .Flush(Flush),
    .CmpResult(CmpResult), .CmpControl(satCmpControl), .ForwardA(satForwardA),
    .ForwardB(satForwardB), .Stall(satStall), .Taken(satTaken),
    .StallCount(satStallCount)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    totalCount++;
    if (act !== req) begin
      $display("[TB] FAIL %s: actual=%0h required=%0h", nm, act, req);
    end else begin
      passedCount++;
    end
  endtask

  function automatic vec_t br(input string nm, input logic vld, input logic [2:0] op,
                              input logic [4:0] rs, input logic [4:0] rt, input logic cmp,
                              input logic [2:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                              input logic st, input logic tk);
    vec_t v;
    v.name = nm; v.valid = vld; v.op = op; v.rs = rs; v.rt = rt;
    v.exW = 1'b0; v.exM = 1'b0; v.exRd = 5'd0;
    v.memW = 1'b0; v.memM = 1'b0; v.memRd = 5'd0;
    v.wbW = 1'b0; v.wbRd = 5'd0;
    v.flush = 1'b0; v.cmp = cmp;
    v.expCtl = ctl; v.expFa = fa; v.expFb = fb; v.expStall = st; v.expTaken = tk;
    return v;
  endfunction

  task automatic driveInputs(input vec_t v);
    BranchValid  = v.valid;  BranchOp    = v.op;
    Rs           = v.rs;     Rt          = v.rt;
    EX_RegWrite  = v.exW;    EX_MemRead  = v.exM;  EX_Rd  = v.exRd;
    MEM_RegWrite = v.memW;   MEM_MemRead = v.memM; MEM_Rd = v.memRd;
    WB_RegWrite  = v.wbW;    WB_Rd       = v.wbRd;
    Flush        = v.flush;  CmpResult   = v.cmp;
  endtask

  // Drive one cycle of stimulus after the falling edge and queue its expectation.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    driveInputs(v);
    e.name = v.name; e.ctl = v.expCtl; e.fa = v.expFa; e.fb = v.expFb;
    e.stall = v.expStall; e.taken = v.expTaken; e.cnt = modelCnt; e.cnt4 = modelCnt4;
    expQ.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the settled outputs.
  task automatic checkOutput();
    exp_t e;
    #2;
    if (expQ.size() == 0) begin
      totalCount++;
      $display("[TB] FAIL scoreboard: actual=empty required=entry");
      return;
    end
    e = expQ.pop_front();
    check({e.name, ".ctl"},   {13'd0, CmpControl},   {13'd0, e.ctl});
    check({e.name, ".fa"},    {14'd0, ForwardA},     {14'd0, e.fa});
    check({e.name, ".fb"},    {14'd0, ForwardB},     {14'd0, e.fb});
    check({e.name, ".stall"}, {15'd0, Stall},        {15'd0, e.stall});
    check({e.name, ".taken"}, {15'd0, Taken},        {15'd0, e.taken});
    check({e.name, ".cnt"},   StallCount,            e.cnt);
    check({e.name, ".cnt4"},  {12'd0, satStallCount}, {12'd0, e.cnt4});
    if (e.stall) begin
      if (modelCnt != 16'hFFFF) modelCnt = modelCnt + 16'd1;
      if (modelCnt4 != 4'hF) modelCnt4 = modelCnt4 + 4'd1;
    end
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  task automatic checkAllZero(input string nm);
    check({nm, ".ctl"},   {13'd0, CmpControl}, 16'd0);
    check({nm, ".fa"},    {14'd0, ForwardA},   16'd0);
    check({nm, ".fb"},    {14'd0, ForwardB},   16'd0);
    check({nm, ".stall"}, {15'd0, Stall},      16'd0);
    check({nm, ".taken"}, {15'd0, Taken},      16'd0);
    check({nm, ".cnt"},   StallCount,          16'd0);
    check({nm, ".cnt4"},  {12'd0, satStallCount}, 16'd0);
  endtask

  initial begin
    vec_t tbl[11];
    vec_t v;
    logic cmpBit;

    // Single-cycle vectors: every one resolves (or is ignored) in IDLE.
    tbl[0]  = br("beq_nohaz_t",  1, 3'b000, 5'd3, 5'd4, 1, 3'b000, 2'b00, 2'b00, 0, 1);
    tbl[1]  = br("beq_nohaz_nt", 1, 3'b000, 5'd3, 5'd4, 0, 3'b000, 2'b00, 2'b00, 0, 0);
    tbl[2]  = br("bgez_exrd0",   1, 3'b001, 5'd0, 5'd1, 1, 3'b001, 2'b00, 2'b00, 0, 1);
    tbl[2].exW = 1; tbl[2].exRd = 5'd0;
    tbl[3]  = br("bgez_exrd1",   1, 3'b001, 5'd0, 5'd1, 0, 3'b001, 2'b00, 2'b00, 0, 0);
    tbl[3].exW = 1; tbl[3].exRd = 5'd1;
    tbl[4]  = br("bne_mem_wb",   1, 3'b101, 5'd8, 5'd9, 0, 3'b101, 2'b01, 2'b10, 0, 0);
    tbl[4].memW = 1; tbl[4].memRd = 5'd8; tbl[4].wbW = 1; tbl[4].wbRd = 5'd9;
    tbl[5]  = br("beq_mem_prio", 1, 3'b000, 5'd6, 5'd6, 1, 3'b000, 2'b01, 2'b01, 0, 1);
    tbl[5].memW = 1; tbl[5].memRd = 5'd6; tbl[5].wbW = 1; tbl[5].wbRd = 5'd6;
    tbl[6]  = br("bltz_rt_skip", 1, 3'b100, 5'd2, 5'd2, 1, 3'b100, 2'b10, 2'b00, 0, 1);
    tbl[6].wbW = 1; tbl[6].wbRd = 5'd2;
    tbl[7]  = br("op110_noop",   1, 3'b110, 5'd7, 5'd0, 1, 3'b110, 2'b00, 2'b00, 0, 0);
    tbl[7].exW = 1; tbl[7].exM = 1; tbl[7].exRd = 5'd7;
    tbl[8]  = br("not_valid",    0, 3'b000, 5'd7, 5'd0, 1, 3'b000, 2'b00, 2'b00, 0, 0);
    tbl[8].exW = 1; tbl[8].exM = 1; tbl[8].exRd = 5'd7;
    tbl[9]  = br("flush_idle",   1, 3'b000, 5'd3, 5'd4, 1, 3'b000, 2'b00, 2'b00, 0, 0);
    tbl[9].flush = 1;
    tbl[10] = br("blez_wb_only", 1, 3'b011, 5'd12, 5'd0, 1, 3'b011, 2'b10, 2'b00, 0, 1);
    tbl[10].memRd = 5'd12; tbl[10].wbW = 1; tbl[10].wbRd = 5'd12;

    // Reset state.
    rst_n = 1'b0;
    driveInputs(br("idle", 0, 3'b000, 5'd0, 5'd0, 0, 3'b000, 2'b00, 2'b00, 0, 0));
    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i]);
    end

    // BNE with an EX ALU producer: one stall, then forward from MEM.
    v = br("bne_exalu_c0", 1, 3'b101, 5'd5, 5'd0, 1, 3'b101, 2'b00, 2'b00, 1, 0);
    v.exW = 1; v.exRd = 5'd5; step(v);
    v = br("bne_exalu_c1", 1, 3'b101, 5'd5, 5'd0, 1, 3'b101, 2'b01, 2'b00, 0, 1);
    v.memW = 1; v.memRd = 5'd5; step(v);
    step(br("bne_exalu_c2", 0, 3'b000, 5'd0, 5'd0, 0, 3'b000, 2'b00, 2'b00, 0, 0));

    // BGTZ after a load into $7: two stalls, then forward from WB.
    // BranchOp is changed during WAIT to confirm the captured op is used.
    v = br("bgtz_exld_c0", 1, 3'b010, 5'd7, 5'd0, 0, 3'b010, 2'b00, 2'b00, 1, 0);
    v.exW = 1; v.exM = 1; v.exRd = 5'd7; step(v);
    step(br("bgtz_exld_c1", 1, 3'b101, 5'd7, 5'd0, 0, 3'b010, 2'b10, 2'b00, 1, 0));
    step(br("bgtz_exld_c2", 1, 3'b101, 5'd7, 5'd0, 1, 3'b010, 2'b10, 2'b00, 0, 1));

    // BEQ after a MEM-stage load into Rt: one stall, then forward from WB.
    v = br("beq_memld_c0", 1, 3'b000, 5'd0, 5'd11, 0, 3'b000, 2'b00, 2'b00, 1, 0);
    v.memW = 1; v.memM = 1; v.memRd = 5'd11; step(v);
    step(br("beq_memld_c1", 1, 3'b000, 5'd0, 5'd11, 0, 3'b000, 2'b00, 2'b10, 0, 0));

    // Flush in the first WAIT cycle aborts the branch, and the next branch
    // resolves in the same cycle.
    v = br("flush_c0", 1, 3'b000, 5'd9, 5'd0, 1, 3'b000, 2'b00, 2'b00, 1, 0);
    v.exW = 1; v.exM = 1; v.exRd = 5'd9; step(v);
    v = br("flush_c1", 1, 3'b000, 5'd9, 5'd0, 1, 3'b000, 2'b10, 2'b00, 0, 0);
    v.flush = 1; step(v);
    step(br("flush_c2", 1, 3'b000, 5'd3, 5'd4, 1, 3'b000, 2'b00, 2'b00, 0, 1));

    // Reset asserted during WAIT clears the outputs without waiting for an edge.
    v = br("rstwait_c0", 1, 3'b011, 5'd10, 5'd0, 1, 3'b011, 2'b00, 2'b00, 1, 0);
    v.exW = 1; v.exM = 1; v.exRd = 5'd10; step(v);
    @(negedge clk);
    driveInputs(br("rstwait_c1", 1, 3'b011, 5'd10, 5'd0, 1, 3'b000, 2'b00, 2'b00, 0, 0));
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("rst_in_wait");
    modelCnt  = 16'd0;
    modelCnt4 = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step(br("after_rst", 1, 3'b000, 5'd3, 5'd4, 1, 3'b000, 2'b00, 2'b00, 0, 1));

    // Repeated load-use branches drive the 4-bit counter into saturation.
    for (int i = 0; i < 9; i++) begin
      cmpBit = i[0];
      v = br("sat_c0", 1, 3'b010, 5'd7, 5'd0, cmpBit, 3'b010, 2'b00, 2'b00, 1, 0);
      v.exW = 1; v.exM = 1; v.exRd = 5'd7; step(v);
      step(br("sat_c1", 1, 3'b010, 5'd7, 5'd0, cmpBit, 3'b010, 2'b10, 2'b00, 1, 0));
      step(br("sat_c2", 1, 3'b010, 5'd7, 5'd0, cmpBit, 3'b010, 2'b10, 2'b00, 0, cmpBit));
    end
    step(br("sat_end", 0, 3'b000, 5'd0, 5'd0, 0, 3'b000, 2'b00, 2'b00, 0, 0));

    $display("%0d/%0d checks passed", passedCount, totalCount);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences the ID-stage branch comparator in the pipelined MIPS core.
- Detects operand hazards for the branch's source registers and stalls IF/ID for the required cycles.
- Selects comparator operand forwarding and drives the comparator's 3-bit operation code.
- Converts the comparator result into a one-cycle PC-redirect/flush pulse, and counts stall cycles.

Parameters:
CNT_W, 16, width of the saturating branch-stall cycle counter

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
BranchValid  input  1  ID stage holds a conditional branch
BranchOp  input  3  000 BEQ, 001 BGEZ, 010 BGTZ, 011 BLEZ, 100 BLTZ, 101 BNE
Rs  input  5  branch source register A
Rt  input  5  branch source register B; BEQ/BNE only
EX_RegWrite, EX_MemRead  input  1 each  EX-stage writeback enable / load flag
EX_Rd  input  5  EX-stage destination register
MEM_RegWrite, MEM_MemRead  input  1 each  MEM-stage writeback enable / load flag
MEM_Rd  input  5  MEM-stage destination register
WB_RegWrite  input  1  WB-stage writeback enable
WB_Rd  input  5  WB-stage destination register
Flush  input  1  external flush (exception/jump); aborts a pending branch
CmpResult  input  1  comparator result
CmpControl  output  3  operation code to comparator
ForwardA, ForwardB  output  2 each  operand select: 00 regfile, 01 MEM ALU result, 10 WB result
Stall  output  1  freeze PC and IF/ID
Taken  output  1  redirect PC to branch target; also flushes IF/ID
StallCount  output  CNT_W  saturating count of branch stall cycles

Behaviour:
- Reset asserted: state IDLE, counter 0, Stall=0, Taken=0, ForwardA/B=00, StallCount=0, CmpControl=000.
- Register 0 never creates a dependency. Rt is checked only for BEQ/BNE.
- Stall need per operand, highest priority first:
  - EX load match: 2 cycles.
  - EX ALU match (RegWrite, no MemRead): 1 cycle.
  - MEM load match: 1 cycle.
  - MEM ALU match: 0 cycles, forward 01.
  - WB match: 0 cycles, forward 10.
  - No match: 0 cycles, forward 00.
- Branch need = max over both operands.
- Post-stall forwarding for a captured operand: EX ALU → 01; EX load or MEM load → 10.
- State IDLE (CmpControl = BranchOp, combinational):
  - BranchValid & need==0: resolve in the same cycle. ForwardA/B come from the live hazard check; Taken = CmpResult; stay IDLE.
  - BranchValid & need>0: Stall=1, Taken=0. Capture BranchOp and post-stall forward selects; cnt <= need-1; go WAIT.
- State WAIT (CmpControl and ForwardA/B from captured registers):
  - cnt!=0: Stall=1, cnt--.
  - cnt==0: Stall=0, Taken=CmpResult, go IDLE.
- Resulting stall lengths: need=1 gives 1 stall cycle, need=2 gives 2 stall cycles; resolve follows on the next cycle.
- Taken is a single-cycle Mealy pulse, never asserted while Stall=1.
- Flush has priority in every state: Stall=0, Taken=0, next state IDLE.
- BranchOp 110/111: no stall, Taken=0.
- StallCount increments every cycle Stall=1 and saturates at all-ones.
- Reset mid-WAIT: immediate return to IDLE with all outputs at reset values.
- A new branch is accepted only in IDLE; BranchValid is ignored while in WAIT (IF/ID is frozen).

Test Plan:
- BEQ Rs=3, Rt=4, no hazards, CmpResult=1 → same cycle: Stall=0, Taken=1, ForwardA/B=00, CmpControl=000.
- BNE Rs=5 with EX_RegWrite=1, EX_Rd=5, EX_MemRead=0 → cycle 0 Stall=1; cycle 1 Stall=0, ForwardA=01, CmpControl=101, Taken=CmpResult; StallCount=1.
- BGTZ Rs=7 with EX load to $7 → Stall=1 for exactly 2 cycles; cycle 2 ForwardA=10, CmpControl=010, Taken=CmpResult; StallCount=2.
- BGEZ Rs=0, Rt=1, EX_Rd=0 and EX_Rd=1 → no stall (Rs is $0, Rt not checked); ForwardA=00; Taken follows CmpResult.
- EX load hazard, then Flush asserted in the first WAIT cycle → Stall=0, Taken=0, IDLE next cycle; Reset low during WAIT → all outputs 0 asynchronously.
- StallCount preloaded by repeated stalls to 16'hFFFF, one more stall cycle → StallCount remains 16'hFFFF.
